// File: rtl/pair_block_averager.sv
// pair_block_averager: two-channel decimating block averager.
// Accumulates 2^LOG2_LEN accepted samples per channel, then emits one block
// average (floor rounding) and one block maximum per channel with a one-cycle
// out_valid pulse. Both channels share the FSM, sample counter and pulse.

// Per-channel datapath: running sum, running max and registered results.
module pair_block_averager_lane #(
    parameter int DATA_W   = 16,
    parameter int LOG2_LEN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              take_first,
    input  logic              take_accum,
    input  logic              take_last,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg,
    output logic [DATA_W-1:0] max
);
    localparam int AW = DATA_W + LOG2_LEN;

    logic [AW-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [AW-1:0]     sample_ext;
    logic [AW-1:0]     sum;
    logic [DATA_W-1:0] new_max;

    assign sample_ext = {{LOG2_LEN{sample[DATA_W-1]}}, sample};
    assign sum        = acc_q + sample_ext;
    assign new_max    = ($signed(sample) > $signed(run_max_q)) ? sample : run_max_q;

    // Next-state for accumulator, running max and held results.
    always_comb begin
        acc_d     = acc_q;
        run_max_d = run_max_q;
        avg_d     = avg_q;
        max_d     = max_q;
        if (clear) begin
            acc_d     = '0;
            run_max_d = '0;
        end else if (take_first) begin
            acc_d     = sample_ext;
            run_max_d = sample;
        end else if (take_last) begin
            // Upper DATA_W bits of the sum are the arithmetic shift by
            // LOG2_LEN, i.e. the floor average truncated to DATA_W.
            avg_d     = sum[AW-1:LOG2_LEN];
            max_d     = new_max;
            acc_d     = '0;
            run_max_d = '0;
        end else if (take_accum) begin
            acc_d     = sum;
            run_max_d = new_max;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            run_max_q <= '0;
            avg_q     <= '0;
            max_q     <= '0;
        end else begin
            acc_q     <= acc_d;
            run_max_q <= run_max_d;
            avg_q     <= avg_d;
            max_q     <= max_d;
        end
    end

    assign avg = avg_q;
    assign max = max_q;
endmodule

module pair_block_averager #(
    parameter int DATA_W   = 16,
    parameter int LOG2_LEN = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_q_0,
    input  logic [DATA_W-1:0] in_q_1,
    output logic              out_valid,
    output logic [DATA_W-1:0] avg_0,
    output logic [DATA_W-1:0] avg_1,
    output logic [DATA_W-1:0] max_0,
    output logic [DATA_W-1:0] max_1,
    output logic [15:0]       block_count
);
    localparam int NUM_LANES = 2;

    typedef enum logic {FIRST = 1'b0, ACCUM = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [LOG2_LEN-1:0] cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         block_count_q, block_count_d;

    logic accept, take_first, take_accum, take_last;

    // Clear wins over any sample, including the one that would end a block.
    assign accept     = in_valid && !clear;
    assign take_first = accept && (state_q == FIRST);
    assign take_last  = accept && (state_q == ACCUM) && (cnt_q == '1);
    assign take_accum = accept && (state_q == ACCUM) && (cnt_q != '1);

    // Shared control: FSM, sample counter, pulse and block counter.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_valid_d   = 1'b0;
        block_count_d = block_count_q;
        if (clear) begin
            state_d = FIRST;
            cnt_d   = '0;
        end else if (take_first) begin
            state_d = ACCUM;
            cnt_d   = LOG2_LEN'(1);
        end else if (take_last) begin
            state_d       = FIRST;
            cnt_d         = '0;
            out_valid_d   = 1'b1;
            block_count_d = block_count_q + 16'd1;
        end else if (take_accum) begin
            cnt_d = cnt_q + LOG2_LEN'(1);
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FIRST;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            block_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            block_count_q <= block_count_d;
        end
    end

    logic [NUM_LANES-1:0][DATA_W-1:0] lane_in, lane_avg, lane_max;

    assign lane_in = {in_q_1, in_q_0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        pair_block_averager_lane #(
            .DATA_W   (DATA_W),
            .LOG2_LEN (LOG2_LEN)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .clear      (clear),
            .take_first (take_first),
            .take_accum (take_accum),
            .take_last  (take_last),
            .sample     (lane_in[g]),
            .avg        (lane_avg[g]),
            .max        (lane_max[g])
        );
    end

    assign out_valid   = out_valid_q;
    assign avg_0       = lane_avg[0];
    assign avg_1       = lane_avg[1];
    assign max_0       = lane_max[0];
    assign max_1       = lane_max[1];
    assign block_count = block_count_q;
endmodule

// File: doc/pair_block_averager.md
# pair_block_averager

Decimating block averager for a pair of signed sample streams, sitting directly downstream of `test_setup` and consuming its `q_0`/`q_1` outputs. It accumulates 2^LOG2_LEN accepted samples per channel, then emits one block average and one block maximum per channel with a single-cycle valid pulse. Accumulation restarts with no dead cycle.

## Interface
- `DATA_W`, 16: sample and result width, signed two's complement.
- `LOG2_LEN`, 4: log2 of block length; block = 2^LOG2_LEN samples (default 16). Legal range is 1..8.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort of the current block.
- `in_valid`  in  1  sample-accept qualifier; tie to 1 when fed every cycle.
- `in_q_0`  in  DATA_W  channel 0 sample, signed.
- `in_q_1`  in  DATA_W  channel 1 sample, signed.
- `out_valid`  out  1  one-cycle pulse; results below are new.
- `avg_0`, `avg_1`  out  DATA_W  block average per channel, signed.
- `max_0`, `max_1`  out  DATA_W  block maximum per channel, signed.
- `block_count`  out  16  number of completed blocks, wraps modulo 2^16.

## Operation
- Internal state:
  - `acc_0`, `acc_1`: signed, DATA_W+LOG2_LEN bits. This width cannot overflow.
  - `run_max_0`, `run_max_1`: DATA_W bits.
  - `cnt`: LOG2_LEN bits.
- FSM has two states:
  - FIRST: no sample yet in the block.
  - ACCUM: at least one sample in the block.
- Sample accepted in FIRST:
  - acc = sign-extended sample.
  - run_max = sample.
  - cnt = 1.
  - Go to ACCUM.
- Sample accepted in ACCUM (not the last): acc += sample, run_max = max(run_max, sample) using a signed compare, cnt += 1.
- Last sample of a block is the sample accepted when cnt == 2^LOG2_LEN−1. When LOG2_LEN=1 this is the sample accepted in ACCUM with cnt==1. On that edge:
  - avg_x = (acc_x + sample_x) >>> LOG2_LEN. This is an arithmetic shift, so it rounds toward −infinity. The result always fits DATA_W and is truncated to DATA_W.
  - max_x = max(run_max_x, sample_x).
  - out_valid = 1 for exactly one cycle.
  - block_count += 1.
  - FSM goes to FIRST. A sample in the very next cycle starts the new block, so there is no gap.
- `in_valid`=0: no state change. out_valid still deasserts after its single cycle.
- `clear`=1, synchronous:
  - FSM goes to FIRST; acc, run_max and cnt go to 0.
  - The in_valid sample in the same cycle is discarded. Clear has priority, including over a would-be last sample.
  - out_valid = 0 next cycle.
  - avg_x, max_x and block_count hold their previous values.
- Outputs avg_x, max_x and block_count are registered and hold between pulses.

## Timing
- Reset (reset_n low, asynchronous assert) sets:
  - out_valid = 0, avg_0 = avg_1 = 0, max_0 = max_1 = 0, block_count = 0.
  - FSM = FIRST, acc = 0, cnt = 0.
- Reset release: samples are accepted from the first rising clk edge with reset_n high.
- Reset mid-block discards the partial block; no out_valid is produced for it.
- Latency: out_valid and the new results are visible in the cycle immediately after the clock edge that accepts the last sample.
- Throughput: one sample per clock per channel. With in_valid held at 1, out_valid pulses every 2^LOG2_LEN cycles.
- Both channels always share cnt, the FSM and out_valid. They are never independent.
- No combinational path from any input to any output.

## Test plan
- Reset, then in_valid=1 with in_q_0=100, in_q_1=−100 for 16 cycles:
  - One out_valid pulse, one cycle after the 16th sample.
  - avg_0=100, avg_1=−100, max_0=100, max_1=−100, block_count=1.
- Ramp in_q_0 = −8..7 (16 samples), in_q_1 = 7..−8:
  - Sum = −8, so avg_0 = avg_1 = −1 (floor rounding).
  - max_0 = 7, max_1 = 7.
- Extremes, 16 samples: in_q_0=32767 and in_q_1=−32768 → avg_0=32767, avg_1=−32768, with no wrap. Then 8×32767 followed by 8×−32768 on channel 0 → avg_0=−1, max_0=32767.
- in_valid toggling 1,0,1,0… with constant 5:
  - out_valid comes only after the 16th accepted sample, i.e. 32 cycles in.
  - avg = 5, and out_valid is never asserted during gaps.
- Sample stream with clear and reset mid-block:
  - Clear after sample 10 of 16 (clear and in_valid high together), then 16 samples of 3: the first pulse shows avg=3, block_count increments once, and avg/max hold old values across the clear.
  - reset_n pulsed low mid-block: all outputs go to 0 immediately (asynchronously), and the next full block completes normally.
- Continuous 3 blocks, in_valid=1: blocks are constants 1, 2, 3.
  - out_valid pulses exactly 16 cycles apart.
  - avg = 1, 2, 3 in order; block_count = 1, 2, 3.
  - No sample is lost at block boundaries.
